// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet FSM states and credit counter sizing.
package noc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } pkt_state_e;

  // Width able to hold every credit value from 0 up to the router buffer depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry flit FIFO. o_ready is registered and tells the producer whether a
// slot will be free on the next cycle, so no combinational valid->ready path.
module noc_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic [1:0]       w_count_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && r_ready;
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_ready = r_ready;

  // Occupancy after this edge; drives both the count and the registered ready.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and ready bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/noc_tx_endpoint.sv
// Transmit endpoint feeding one router local input port with credit-based
// flow control. User flits are queued in a 2-entry buffer and released only
// when the router has a free buffer slot (or is returning one this cycle).
//
// state | meaning
// IDLE  | next flit sent is the head of a new packet
// BODY  | head sent, waiting for the tail flit to leave
module noc_tx_endpoint
  import noc_pkg::*;
#(
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] s_data,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [31:0]           pkt_count
);

  localparam int            CW         = credit_width(FLIT_BUFFER_DEPTH);
  localparam int            EW         = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

  logic                  w_fifo_ready;
  logic                  w_fifo_empty;
  logic                  w_accept;
  logic                  w_send;
  logic [EW-1:0]         w_entry;
  logic [EW-1:0]         w_head;
  logic [DEST_WIDTH-1:0] w_entry_dest;
  logic                  w_head_tail;
  logic [DEST_WIDTH-1:0] w_head_dest;
  logic [FLIT_WIDTH-1:0] w_head_data;

  logic                  r_in_head;
  logic [DEST_WIDTH-1:0] r_in_dest;
  logic [CW-1:0]         r_credits;
  pkt_state_e            r_state;
  logic                  r_send;
  logic [FLIT_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic                  r_tail;
  logic [31:0]           r_pkt_count;

  assign w_accept     = s_valid && w_fifo_ready;
  assign w_entry_dest = r_in_head ? s_dest : r_in_dest;
  assign w_entry      = {s_last, w_entry_dest, s_data};

  assign w_head_tail  = w_head[EW-1];
  assign w_head_dest  = w_head[FLIT_WIDTH +: DEST_WIDTH];
  assign w_head_data  = w_head[FLIT_WIDTH-1:0];

  // A credit arriving this cycle can be spent immediately even at zero.
  assign w_send = !w_fifo_empty && ((r_credits != '0) || credit_in);

  noc_skid_buffer #(
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  (w_entry),
    .i_pop   (w_send),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_ready (w_fifo_ready)
  );

  // Input-side packet tracking: head flits capture s_dest, later flits reuse it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_head <= 1'b1;
      r_in_dest <= '0;
    end else if (w_accept) begin
      r_in_head <= s_last;
      if (r_in_head) r_in_dest <= s_dest;
    end
  end

  // Router buffer credits; a send and a returned credit in one cycle cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_credits <= CREDIT_MAX;
    end else begin
      case ({w_send, credit_in})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   if (r_credits != CREDIT_MAX) r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Packet FSM with registered flit outputs and tail counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_send      <= 1'b0;
      r_data      <= '0;
      r_dest      <= '0;
      r_tail      <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_send <= w_send;
      if (w_send) begin
        r_data <= w_head_data;
        r_dest <= w_head_dest;
        r_tail <= w_head_tail;
        if (w_head_tail) r_pkt_count <= r_pkt_count + 32'd1;
        case (r_state)
          IDLE:    if (!w_head_tail) r_state <= BODY;
          BODY:    if (w_head_tail)  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // The router never owns more slots than its buffer depth.
  a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(credit_in && (r_credits == CREDIT_MAX)));

  assign s_ready     = w_fifo_ready;
  assign send_out    = r_send;
  assign data_out    = r_data;
  assign dest_out    = r_dest;
  assign is_tail_out = r_tail;
  assign pkt_count   = r_pkt_count;

endmodule
